data_bus_control: RTL and testbench

DATA_BUS_CONTROL -- requirements
Module: data_bus_control

---
 rtl/data_bus_control.sv | 144 ++++++++++++++
 tb/tb_data_bus_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_control.sv
// CPU data-bus and interrupt-acknowledge sequencer for an 8259-style interrupt controller.
// Strobes are synchronized, edge-detected, and all bus-facing outputs are registered.
module data_bus_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic       inta_n,
    input  logic [7:0] d_in,
    input  logic       mode_8086,
    input  logic [4:0] vector_t,
    input  logic [7:0] addr_hi,
    input  logic [2:0] int_level,
    input  logic       int_pending,
    input  logic       slave_owns_vector,
    input  logic       read_isr,
    input  logic       poll_cmd,
    input  logic [7:0] irr,
    input  logic [7:0] isr,
    input  logic [7:0] imr,
    output logic       buf_oe,
    output logic [7:0] buf_dout,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    output logic       wr_a0,
    output logic       freeze,
    output logic       ack_pulse,
    output logic [2:0] ack_level
);

    typedef enum logic [2:0] {StIdle, StP1, StG1, StP2, StG2, StP3} state_e;

    state_e     state_q, state_d;
    // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detect
    logic [2:0] rd_sync_q, wr_sync_q, inta_sync_q;
    logic       rd_block_q, rd_block_d;

    logic       inta_fall, inta_rise, rd_low, rd_rise, wr_low, wr_rise;
    logic       cpu_rd, poll_ack, wr_fire, ack_entry;
    logic       oe_d;
    logic [7:0] dout_d;
    logic [2:0] ack_level_d;

    always_comb begin
        inta_fall = inta_sync_q[2] & ~inta_sync_q[1];
        inta_rise = ~inta_sync_q[2] & inta_sync_q[1];
        rd_low    = ~rd_sync_q[1];
        rd_rise   = ~rd_sync_q[2] & rd_sync_q[1];
        wr_low    = ~wr_sync_q[1];
        wr_rise   = ~wr_sync_q[2] & wr_sync_q[1];

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (inta_fall) state_d = StP1;
            StP1:    if (inta_rise) state_d = StG1;
            StG1:    if (inta_fall) state_d = StP2;
            StP2:    if (inta_rise) state_d = mode_8086 ? StIdle : StG2;
            StG2:    if (inta_fall) state_d = StP3;
            StP3:    if (inta_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A read overlapping any part of an INTA sequence stays undriven until rd is released
        rd_block_d = rd_low & (rd_block_q | (state_d != StIdle));
        cpu_rd     = ~cs_n & rd_low & ~wr_low & ~rd_block_q & (state_d == StIdle);
        poll_ack   = (state_q == StIdle) & (state_d == StIdle) & ~cs_n & rd_rise
                   & wr_sync_q[1] & ~rd_block_q & poll_cmd & int_pending;
        // rd must have been high on both sides so a simultaneous rd/wr release is not a write
        wr_fire    = (state_q == StIdle) & ~cs_n & wr_rise & rd_sync_q[1] & rd_sync_q[2];
        ack_entry  = (state_q == StIdle) & (state_d == StP1);

        ack_level_d = ack_level;
        if (ack_entry || poll_ack) ack_level_d = int_level;

        oe_d   = 1'b0;
        dout_d = 8'h00;
        unique case (state_d)
            StP1: begin
                if (!mode_8086) begin
                    oe_d   = 1'b1;
                    dout_d = 8'hCD;
                end
            end
            StP2: begin
                oe_d   = ~slave_owns_vector;
                dout_d = mode_8086 ? {vector_t, ack_level_d}
                                   : {vector_t[4:2], ack_level_d, 2'b00};
            end
            StP3: begin
                oe_d   = ~slave_owns_vector;
                dout_d = addr_hi;
            end
            StIdle: begin
                if (cpu_rd) begin
                    oe_d = 1'b1;
                    if (poll_cmd)  dout_d = {int_pending, 4'b0000, int_level};
                    else if (a0)   dout_d = imr;
                    else           dout_d = read_isr ? isr : irr;
                end
            end
            default: begin
                oe_d   = 1'b0;
                dout_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_sync_q   <= 3'b111;
            wr_sync_q   <= 3'b111;
            inta_sync_q <= 3'b111;
            rd_block_q  <= 1'b0;
            buf_oe      <= 1'b0;
            buf_dout    <= 8'h00;
            wr_valid    <= 1'b0;
            wr_data     <= 8'h00;
            wr_a0       <= 1'b0;
            freeze      <= 1'b0;
            ack_pulse   <= 1'b0;
            ack_level   <= 3'd0;
        end else begin
            state_q     <= state_d;
            rd_sync_q   <= {rd_sync_q[1:0], rd_n};
            wr_sync_q   <= {wr_sync_q[1:0], wr_n};
            inta_sync_q <= {inta_sync_q[1:0], inta_n};
            rd_block_q  <= rd_block_d;
            buf_oe      <= oe_d;
            buf_dout    <= dout_d;
            wr_valid    <= wr_fire;
            if (wr_fire) begin
                wr_data <= d_in;
                wr_a0   <= a0;
            end
            freeze      <= (state_d != StIdle);
            ack_pulse   <= ack_entry | poll_ack;
            ack_level   <= ack_level_d;
        end
    end

endmodule

// File: tb/tb_data_bus_control.sv
// Directed bench for data_bus_control: INTA sequences, CPU reads/writes, poll and reset abort.
module tb_data_bus_control;

    logic       clk = 1'b0;
    logic       rst_n, cs_n, rd_n, wr_n, a0, inta_n;
    logic [7:0] d_in;
    logic       mode_8086;
    logic [4:0] vector_t;
    logic [7:0] addr_hi;
    logic [2:0] int_level;
    logic       int_pending, slave_owns_vector, read_isr, poll_cmd;
    logic [7:0] irr, isr, imr;
    logic       buf_oe;
    logic [7:0] buf_dout;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_a0, freeze, ack_pulse;
    logic [2:0] ack_level;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int wr_cnt = 0;
    int base;

    data_bus_control dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .inta_n(inta_n), .d_in(d_in), .mode_8086(mode_8086), .vector_t(vector_t),
        .addr_hi(addr_hi), .int_level(int_level), .int_pending(int_pending),
        .slave_owns_vector(slave_owns_vector), .read_isr(read_isr), .poll_cmd(poll_cmd),
        .irr(irr), .isr(isr), .imr(imr), .buf_oe(buf_oe), .buf_dout(buf_dout),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_a0(wr_a0), .freeze(freeze),
        .ack_pulse(ack_pulse), .ack_level(ack_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack_pulse) ack_cnt++;
        if (wr_valid)  wr_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic inta_low(input string tag, input logic exp_oe, input logic [7:0] exp_dout);
        inta_n = 1'b0;
        tick(3);
        check({tag, "_oe"}, 8'(buf_oe), 8'(exp_oe));
        if (exp_oe) check({tag, "_dout"}, buf_dout, exp_dout);
        check({tag, "_freeze"}, 8'(freeze), 8'h01);
        tick(2);
    endtask

    task automatic inta_high(input string tag, input logic exp_freeze);
        inta_n = 1'b1;
        tick(3);
        check({tag, "_oe"}, 8'(buf_oe), 8'h00);
        check({tag, "_freeze"}, 8'(freeze), 8'(exp_freeze));
        tick(2);
    endtask

    task automatic cpu_read(input string tag, input logic [7:0] exp);
        cs_n = 1'b0;
        rd_n = 1'b0;
        tick(3);
        check({tag, "_oe"}, 8'(buf_oe), 8'h01);
        check({tag, "_dout"}, buf_dout, exp);
        rd_n = 1'b1;
        tick(3);
        check({tag, "_oe_off"}, 8'(buf_oe), 8'h00);
        tick(2);
        cs_n = 1'b1;
    endtask

    task automatic cpu_write(input logic sel_n, input logic addr, input logic [7:0] data);
        cs_n = sel_n;
        a0   = addr;
        d_in = data;
        wr_n = 1'b0;
        tick(3);
        wr_n = 1'b1;
        tick(4);
        cs_n = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; inta_n = 1'b1;
        d_in = 8'h00; mode_8086 = 1'b1; vector_t = 5'b01000; addr_hi = 8'h12;
        int_level = 3'd3; int_pending = 1'b0; slave_owns_vector = 1'b0;
        read_isr = 1'b0; poll_cmd = 1'b0; irr = 8'hA5; isr = 8'h0F; imr = 8'hF0;
        tick(3);
        check("rst_oe", 8'(buf_oe), 8'h00);
        check("rst_dout", buf_dout, 8'h00);
        check("rst_wr_valid", 8'(wr_valid), 8'h00);
        check("rst_freeze", 8'(freeze), 8'h00);
        check("rst_ack", {4'h0, ack_pulse, ack_level}, 8'h00);
        rst_n = 1'b1;
        tick(3);

        // 8086 two-pulse INTA; level changes after P1 must not affect the vector
        base = ack_cnt;
        inta_low("i86_p1", 1'b0, 8'h00);
        check("i86_ack_level", 8'(ack_level), 8'h03);
        int_level = 3'd7;
        inta_high("i86_g1", 1'b1);
        inta_low("i86_p2", 1'b1, 8'h43);
        inta_high("i86_end", 1'b0);
        check("i86_ack_cnt", 8'(ack_cnt - base), 8'h01);

        // 8080 three-pulse INTA
        mode_8086 = 1'b0; vector_t = 5'b10100; int_level = 3'd5; addr_hi = 8'h12;
        base = ack_cnt;
        inta_low("i80_p1", 1'b1, 8'hCD);
        inta_high("i80_g1", 1'b1);
        inta_low("i80_p2", 1'b1, 8'hB4);
        inta_high("i80_g2", 1'b1);
        inta_low("i80_p3", 1'b1, 8'h12);
        inta_high("i80_end", 1'b0);
        check("i80_ack_cnt", 8'(ack_cnt - base), 8'h01);
        check("i80_ack_level", 8'(ack_level), 8'h05);

        // Cascaded slave owns vector bytes; writes during the sequence are ignored
        slave_owns_vector = 1'b1;
        inta_low("slv_p1", 1'b1, 8'hCD);
        inta_high("slv_g1", 1'b1);
        base = wr_cnt;
        cpu_write(1'b0, 1'b0, 8'h55);
        check("wr_ignored_busy", 8'(wr_cnt - base), 8'h00);
        inta_low("slv_p2", 1'b0, 8'h00);
        inta_high("slv_g2", 1'b1);
        inta_low("slv_p3", 1'b0, 8'h00);
        inta_high("slv_end", 1'b0);
        slave_owns_vector = 1'b0;

        // CPU register reads
        read_isr = 1'b0; a0 = 1'b0;
        cpu_read("rd_irr", 8'hA5);
        read_isr = 1'b1;
        cpu_read("rd_isr", 8'h0F);
        a0 = 1'b1;
        cpu_read("rd_imr", 8'hF0);
        a0 = 1'b0; read_isr = 1'b0;

        // Poll read acknowledges on rd release
        poll_cmd = 1'b1; int_pending = 1'b1; int_level = 3'd6;
        base = ack_cnt;
        cpu_read("poll", 8'h86);
        check("poll_ack_cnt", 8'(ack_cnt - base), 8'h01);
        check("poll_ack_level", 8'(ack_level), 8'h06);
        int_pending = 1'b0; int_level = 3'd2;
        base = ack_cnt;
        cpu_read("poll_none", 8'h02);
        check("poll_none_ack", 8'(ack_cnt - base), 8'h00);
        poll_cmd = 1'b0;

        // Writes
        base = wr_cnt;
        cs_n = 1'b0; a0 = 1'b1; d_in = 8'h3C; wr_n = 1'b0;
        tick(3);
        wr_n = 1'b1;
        tick(3);
        check("wr_valid", 8'(wr_valid), 8'h01);
        check("wr_data", wr_data, 8'h3C);
        check("wr_a0", 8'(wr_a0), 8'h01);
        tick(2);
        cs_n = 1'b1;
        check("wr_one_pulse", 8'(wr_cnt - base), 8'h01);
        base = wr_cnt;
        cpu_write(1'b1, 1'b0, 8'h77);
        check("wr_no_cs", 8'(wr_cnt - base), 8'h00);

        // rd and wr low together: no drive, no write
        base = wr_cnt;
        cs_n = 1'b0; a0 = 1'b0; d_in = 8'h99; rd_n = 1'b0; wr_n = 1'b0;
        tick(3);
        check("rdwr_oe", 8'(buf_oe), 8'h00);
        rd_n = 1'b1; wr_n = 1'b1;
        tick(5);
        cs_n = 1'b1;
        check("rdwr_no_wr", 8'(wr_cnt - base), 8'h00);

        // INTA preempts an active read; the read stays undriven afterwards
        mode_8086 = 1'b1; vector_t = 5'b01000; int_level = 3'd3;
        cs_n = 1'b0; rd_n = 1'b0;
        tick(3);
        check("pre_rd_dout", buf_dout, 8'hA5);
        inta_low("pre_p1", 1'b0, 8'h00);
        inta_high("pre_g1", 1'b1);
        inta_low("pre_p2", 1'b1, 8'h43);
        inta_high("pre_end", 1'b0);
        rd_n = 1'b1;
        tick(3);
        cs_n = 1'b1;

        // Reset in 8080 P2 aborts; next pulse starts fresh at P1
        mode_8086 = 1'b0; vector_t = 5'b10100; int_level = 3'd5;
        inta_low("ra_p1", 1'b1, 8'hCD);
        inta_high("ra_g1", 1'b1);
        inta_low("ra_p2", 1'b1, 8'hB4);
        base = ack_cnt;
        rst_n = 1'b0;
        #1;
        check("ra_oe", 8'(buf_oe), 8'h00);
        check("ra_freeze", 8'(freeze), 8'h00);
        inta_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("ra_no_ack", 8'(ack_cnt - base), 8'h00);
        inta_low("ra_new_p1", 1'b1, 8'hCD);
        check("ra_new_ack", 8'(ack_cnt - base), 8'h01);
        inta_high("ra_new_g1", 1'b1);
        inta_low("ra_new_p2", 1'b1, 8'hB4);
        inta_high("ra_new_g2", 1'b1);
        inta_low("ra_new_p3", 1'b1, 8'h12);
        inta_high("ra_new_end", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
